niosii_system_sysid_checker: RTL and testbench

Boot-time system-ID verifier for the Nios II system. After reset it acts as an Avalon-MM master on the sysid control slave: it reads the ID word (address 0) and the timestamp word (address 1), compares them against expected values, and holds the CPU reset low until both match. Its status is exposed on a small Avalon-MM slave that the debug host reads. It retries a bounded number of times before latching a failure and raising an interrupt.

---
 rtl/niosii_system_sysid_checker.sv | 219 +++++++++++++++++++++
 tb/tb_niosii_system_sysid_checker.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_system_sysid_checker.sv
// niosii_system_sysid_checker
// Boot-time sysid verifier. Reads the sysid ID and timestamp words over an
// Avalon-MM master port, keeps the CPU in reset until both match, retries a
// bounded number of times and raises a level interrupt on final failure.
// A small Avalon-MM status slave exposes progress and accepts restart/clear.
//
// state  | meaning
// IDLE   | first cycle after reset release
// RD_ID  | reading sysid word 0 (ID)
// RD_TS  | reading sysid word 1 (timestamp)
// CHECK  | compare captured words against expected values
// GAP    | idle spacing before the next attempt
// PASS   | check succeeded, CPU released from reset
// FAIL   | retries exhausted, interrupt raised
module niosii_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1487187390,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned RETRY_GAP          = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        cpu_reset_n_out,
    output logic        irq
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        CHECK = 3'd3,
        GAP   = 3'd4,
        PASS  = 3'd5,
        FAIL  = 3'd6
    } state_t;

    localparam logic [7:0]  TMO_LIM   = TIMEOUT_CYCLES[7:0];
    localparam int unsigned GAP_M1    = (RETRY_GAP > 0) ? RETRY_GAP - 1 : 0;
    localparam logic [7:0]  GAP_LAST  = GAP_M1[7:0];
    localparam logic [3:0]  RETRY_LIM = MAX_RETRIES[3:0];

    state_t      state_q, state_d;
    logic [3:0]  att_q, att_d;
    logic        tmo_q, tmo_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  gap_q, gap_d;
    logic        cpu_q, cpu_d;
    logic        irq_q, irq_d;
    logic        m_read_q, m_read_d;
    logic        m_addr_q, m_addr_d;
    logic [31:0] s_rdata_q, s_rdata_d;

    logic        ctrl_wr;
    logic        busy;
    logic [31:0] status_word;
    logic        unused_wdata;

    assign unused_wdata = ^s_writedata[31:2];

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        att_d     = att_q;
        tmo_d     = tmo_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;
        wait_d    = wait_q;
        gap_d     = gap_q;
        cpu_d     = cpu_q;
        irq_d     = irq_q;
        s_rdata_d = s_rdata_q;

        ctrl_wr = s_write && (s_address == 2'd3);
        busy    = (state_q == RD_ID) || (state_q == RD_TS) ||
                  (state_q == CHECK) || (state_q == GAP);
        status_word = {22'b0, att_q, tmo_q, 2'b0, busy,
                       (state_q == FAIL), (state_q == PASS)};

        if (ctrl_wr && s_writedata[1]) begin
            irq_d = 1'b0;
        end

        case (state_q)
            IDLE: state_d = RD_ID;
            RD_ID: begin
                if (!m_waitrequest) begin
                    cap_id_d = m_readdata;
                    state_d  = RD_TS;
                end else if (wait_q == TMO_LIM) begin
                    tmo_d   = 1'b1;
                    state_d = CHECK;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RD_TS: begin
                if (!m_waitrequest) begin
                    cap_ts_d = m_readdata;
                    state_d  = CHECK;
                end else if (wait_q == TMO_LIM) begin
                    tmo_d   = 1'b1;
                    state_d = CHECK;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            CHECK: begin
                if (!tmo_q && (cap_id_q == EXPECTED_ID) &&
                    (cap_ts_q == EXPECTED_TIMESTAMP)) begin
                    state_d = PASS;
                end else if (att_q < RETRY_LIM) begin
                    att_d   = att_q + 4'd1;
                    state_d = GAP;
                end else begin
                    state_d = FAIL;
                    // Entering FAIL wins over a same-cycle irq clear.
                    irq_d   = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = RD_ID;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            PASS, FAIL: begin
                if (ctrl_wr && s_writedata[0]) begin
                    state_d = RD_ID;
                    att_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counters restart on every state entry; the timeout flag belongs to
        // the attempt in progress, so it clears when a new read sequence begins.
        if (state_d != state_q) begin
            wait_d = 8'd0;
            gap_d  = 8'd0;
        end
        if ((state_d == RD_ID) && (state_q != RD_ID)) begin
            tmo_d = 1'b0;
        end
        if (state_d == PASS) begin
            cpu_d = 1'b1;
        end

        // Master strobes are registered from the next state so they are
        // asserted in the same cycle the read state is occupied.
        m_read_d = (state_d == RD_ID) || (state_d == RD_TS);
        if (state_d == RD_TS) begin
            m_addr_d = 1'b1;
        end else if (state_d == RD_ID) begin
            m_addr_d = 1'b0;
        end else begin
            m_addr_d = m_addr_q;
        end

        if (s_read) begin
            case (s_address)
                2'd0:    s_rdata_d = status_word;
                2'd1:    s_rdata_d = cap_id_q;
                2'd2:    s_rdata_d = cap_ts_q;
                default: s_rdata_d = 32'd0;
            endcase
        end
    end

    // All state and output flops, asynchronously cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            att_q     <= 4'd0;
            tmo_q     <= 1'b0;
            cap_id_q  <= 32'd0;
            cap_ts_q  <= 32'd0;
            wait_q    <= 8'd0;
            gap_q     <= 8'd0;
            cpu_q     <= 1'b0;
            irq_q     <= 1'b0;
            m_read_q  <= 1'b0;
            m_addr_q  <= 1'b0;
            s_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            att_q     <= att_d;
            tmo_q     <= tmo_d;
            cap_id_q  <= cap_id_d;
            cap_ts_q  <= cap_ts_d;
            wait_q    <= wait_d;
            gap_q     <= gap_d;
            cpu_q     <= cpu_d;
            irq_q     <= irq_d;
            m_read_q  <= m_read_d;
            m_addr_q  <= m_addr_d;
            s_rdata_q <= s_rdata_d;
        end
    end

    assign m_read          = m_read_q;
    assign m_address       = m_addr_q;
    assign cpu_reset_n_out = cpu_q;
    assign irq             = irq_q;
    assign s_readdata      = s_rdata_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Bench for niosii_system_sysid_checker: a configurable sysid slave, an
// attempt-level schedule model of the expected output waveform, and a
// per-cycle compare process, plus hand-computed status literals.
module tb_niosii_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1487187390;
    localparam int MAXR  = 3;
    localparam int TMO   = 255;
    localparam int GAPN  = 16;
    localparam int SLEN  = 4096;
    localparam int NEVER = 1000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        m_address, m_read;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_readdata = 32'd0;
    logic [1:0]  s_address = 2'd0;
    logic        s_read = 1'b0, s_write = 1'b0;
    logic [31:0] s_writedata = 32'd0;
    logic [31:0] s_readdata;
    logic        cpu_reset_n_out, irq;

    niosii_system_sysid_checker dut (
        .clock(clock), .reset_n(reset_n),
        .m_address(m_address), .m_read(m_read),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .cpu_reset_n_out(cpu_reset_n_out), .irq(irq)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // slave configuration, one entry per attempt
    int          stall_id [8];
    int          stall_ts [8];
    logic [31:0] id_v [8];
    logic [31:0] ts_v [8];
    int          cfg_gen = 0;

    // model state
    bit          s_rd [SLEN];
    bit          s_ad [SLEN];
    bit          s_cpu [SLEN];
    bit          s_irq [SLEN];
    int          sched_len = 1;
    int          base = 0;
    bit          chk_en = 1'b0;
    logic [31:0] mdl_cap_id = 32'd0;
    logic [31:0] mdl_cap_ts = 32'd0;
    int          exp_att = 0;
    bit          exp_tmo = 1'b0, exp_pass = 1'b0, exp_fail = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Sysid slave: per transaction, hold waitrequest for the configured
    // number of cycles, then present the configured data.
    initial begin : slave
        int  xfer, att, seen_gen, idx;
        bit  prev_rd, prev_wr, prev_ad, fresh;
        xfer = 0; att = -1; seen_gen = 0;
        prev_rd = 0; prev_wr = 0; prev_ad = 0;
        forever begin
            @(posedge clock);
            #1;
            if (cfg_gen != seen_gen) begin
                seen_gen = cfg_gen;
                att = -1;
            end
            if (!reset_n) begin
                att = -1;
                m_waitrequest = 1'b0;
            end else if (m_read) begin
                fresh = !prev_rd || !prev_wr || (m_address != prev_ad);
                if (fresh) begin
                    xfer = 0;
                    if (!m_address) att++;
                end else begin
                    xfer++;
                end
                idx = (att < 0) ? 0 : (att > 7 ? 7 : att);
                m_waitrequest = xfer < (m_address ? stall_ts[idx] : stall_id[idx]);
                m_readdata = m_address ? ts_v[idx] : id_v[idx];
            end else begin
                m_waitrequest = 1'b0;
            end
            prev_rd = m_read;
            prev_wr = m_waitrequest;
            prev_ad = m_address;
        end
    end

    task automatic put(input int t, input int d, input bit rd, input bit ad,
                       input bit cp, input bit iq);
        for (int i = 0; i < d; i++) begin
            if (t + i < SLEN) begin
                s_rd[t+i] = rd; s_ad[t+i] = ad; s_cpu[t+i] = cp; s_irq[t+i] = iq;
            end
        end
    endtask

    // Expected waveform of one check run, relative to the triggering edge.
    // Each read lasts stall+1 cycles, or TMO+1 cycles when the slave stalls
    // longer than TMO; an ID timeout skips the timestamp read.
    task automatic build_run(input bit cpu_old, input bit irq_old, input bit irq_run);
        int t, a, d;
        bit tmo, ok;
        put(0, 1, 0, 0, cpu_old, irq_old);
        t = 1; a = 0;
        while (1) begin
            tmo = stall_id[a] > TMO;
            d = tmo ? TMO + 1 : stall_id[a] + 1;
            put(t, d, 1, 0, cpu_old, irq_run); t += d;
            if (!tmo) begin
                mdl_cap_id = id_v[a];
                tmo = stall_ts[a] > TMO;
                d = tmo ? TMO + 1 : stall_ts[a] + 1;
                put(t, d, 1, 1, cpu_old, irq_run); t += d;
                if (!tmo) mdl_cap_ts = ts_v[a];
            end
            put(t, 1, 0, 0, cpu_old, irq_run); t++;
            ok = !tmo && (mdl_cap_id == EXP_ID) && (mdl_cap_ts == EXP_TS);
            if (ok) begin
                put(t, 1, 0, 0, 1'b1, irq_run);
                exp_att = a; exp_tmo = 0; exp_pass = 1; exp_fail = 0;
                break;
            end
            if (a < MAXR) begin
                put(t, GAPN, 0, 0, cpu_old, irq_run); t += GAPN; a++;
            end else begin
                put(t, 1, 0, 0, cpu_old, 1'b1);
                exp_att = a; exp_tmo = tmo; exp_pass = 0; exp_fail = 1;
                break;
            end
        end
        sched_len = t + 1;
    endtask

    function automatic logic [31:0] exp_status();
        return (32'(exp_att) << 6) | (32'(exp_tmo) << 5) | (32'(exp_fail) << 1) | 32'(exp_pass);
    endfunction

    // Per-cycle comparison against the schedule; past its end the last
    // entry is the expected steady state.
    always @(negedge clock) begin : cmp
        int r;
        if (chk_en) begin
            r = cyc - base;
            if (r >= sched_len) r = sched_len - 1;
            if (r >= 0 && r < SLEN) begin
                chk("m_read", {31'b0, m_read}, {31'b0, s_rd[r]});
                if (s_rd[r]) chk("m_address", {31'b0, m_address}, {31'b0, s_ad[r]});
                chk("cpu_reset_n_out", {31'b0, cpu_reset_n_out}, {31'b0, s_cpu[r]});
                chk("irq", {31'b0, irq}, {31'b0, s_irq[r]});
            end
        end
    end

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        @(posedge clock); #2;
        s_read = 1'b1; s_address = a;
        @(posedge clock); #1;
        d = s_readdata;
        #1;
        s_read = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        @(posedge clock); #2;
        s_write = 1'b1; s_address = a; s_writedata = d;
        @(posedge clock); #2;
        s_write = 1'b0;
    endtask

    task automatic cfg_all(input logic [31:0] idv, input logic [31:0] tsv);
        for (int i = 0; i < 8; i++) begin
            stall_id[i] = 0; stall_ts[i] = 0; id_v[i] = idv; ts_v[i] = tsv;
        end
        cfg_gen++;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        #1;
        reset_n = 1'b0;
        s_read = 1'b0; s_write = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        mdl_cap_id = 32'd0; mdl_cap_ts = 32'd0;
    endtask

    task automatic release_run();
        build_run(1'b0, 1'b0, 1'b0);
        base = cyc;
        reset_n = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic wait_sched();
        while (cyc < base + sched_len + 2) @(posedge clock);
        #2;
    endtask

    task automatic check_status(input string nm, input logic [31:0] lit);
        logic [31:0] d;
        rd_reg(2'd0, d);
        chk({nm, "_lit"}, d, lit);
        chk({nm, "_model"}, d, exp_status());
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] d;
        int n;

        // 1: matching slave, zero-wait fabric
        cfg_all(EXP_ID, EXP_TS);
        do_reset();
        chk("rst_m_read", {31'b0, m_read}, 32'd0);
        chk("rst_m_address", {31'b0, m_address}, 32'd0);
        chk("rst_cpu", {31'b0, cpu_reset_n_out}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_s_readdata", s_readdata, 32'd0);
        release_run();
        repeat (3) @(posedge clock);
        #1 chk("cpu_low_cycle3", {31'b0, cpu_reset_n_out}, 32'd0);
        @(posedge clock);
        #1 chk("cpu_high_cycle4", {31'b0, cpu_reset_n_out}, 32'd1);
        #1;
        wait_sched();
        check_status("s1_status", 32'h001);
        rd_reg(2'd1, d); chk("s1_cap_id", d, 32'd0);
        rd_reg(2'd2, d); chk("s1_cap_ts", d, EXP_TS);
        rd_reg(2'd3, d); chk("s1_addr3", d, 32'd0);
        wr_reg(2'd0, 32'h3);
        wr_reg(2'd2, 32'h1);
        repeat (4) @(posedge clock);
        #2;
        check_status("s1_status_after_ignored_wr", 32'h001);

        // 2: ID mismatch on every attempt, then restart from FAIL
        cfg_all(32'h5, EXP_TS);
        do_reset();
        release_run();
        wait_sched();
        check_status("s2_status", 32'h0C2);
        rd_reg(2'd1, d); chk("s2_cap_id", d, 32'h5);
        chk("s2_irq_lit", {31'b0, irq}, 32'd1);
        chk("s2_cpu_lit", {31'b0, cpu_reset_n_out}, 32'd0);

        chk_en = 1'b0;
        cfg_all(EXP_ID, EXP_TS);
        stall_id[0] = 6;
        @(posedge clock); #2;
        build_run(1'b0, 1'b1, 1'b0);
        base = cyc;
        s_write = 1'b1; s_address = 2'd3; s_writedata = 32'h3;
        chk_en = 1'b1;
        @(posedge clock);
        #1 chk("s2_irq_cleared", {31'b0, irq}, 32'd0);
        #1 s_write = 1'b0;
        @(posedge clock); #2;
        s_write = 1'b1; s_writedata = 32'h1;
        @(posedge clock); #2;
        s_write = 1'b0;
        wait_sched();
        check_status("s2_restart_status", 32'h001);

        // 3: stalls at and beyond the timeout boundary on every attempt
        cfg_all(EXP_ID, EXP_TS);
        stall_id[0] = TMO; id_v[0] = 32'h1234; stall_ts[0] = NEVER;
        stall_id[1] = TMO + 1;
        stall_id[2] = NEVER;
        stall_id[3] = NEVER;
        do_reset();
        release_run();
        wait_sched();
        check_status("s3_status", 32'h0E2);
        rd_reg(2'd1, d); chk("s3_cap_id", d, 32'h1234);
        rd_reg(2'd2, d); chk("s3_cap_ts", d, 32'd0);

        // 4: first attempt mismatches, second matches; restart from PASS
        cfg_all(EXP_ID, EXP_TS);
        stall_id[0] = 2; stall_ts[0] = 3; ts_v[0] = EXP_TS + 32'd1;
        stall_ts[1] = 4;
        do_reset();
        release_run();
        wait_sched();
        check_status("s4_status", 32'h041);

        chk_en = 1'b0;
        cfg_all(EXP_ID, EXP_TS);
        stall_id[0] = 1;
        @(posedge clock); #2;
        build_run(1'b1, 1'b0, 1'b0);
        base = cyc;
        s_write = 1'b1; s_address = 2'd3; s_writedata = 32'h1;
        chk_en = 1'b1;
        @(posedge clock); #2;
        s_write = 1'b0;
        wait_sched();
        check_status("s4_restart_status", 32'h001);

        // 5: reset pulse during a stalled timestamp read
        cfg_all(EXP_ID, EXP_TS);
        stall_ts[0] = NEVER;
        do_reset();
        reset_n = 1'b1;
        n = 0;
        while (!(m_read && m_address) && n < 50) begin
            @(posedge clock); #1; n++;
        end
        chk("s5_reached_rd_ts", {31'b0, m_read && m_address}, 32'd1);
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("s5_async_m_read", {31'b0, m_read}, 32'd0);
        chk("s5_async_cpu", {31'b0, cpu_reset_n_out}, 32'd0);
        chk("s5_async_irq", {31'b0, irq}, 32'd0);
        cfg_all(EXP_ID, EXP_TS);
        mdl_cap_id = 32'd0; mdl_cap_ts = 32'd0;
        repeat (2) @(posedge clock);
        #2;
        release_run();
        wait_sched();
        check_status("s5_status", 32'h001);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
